regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Sequences the single write port of the 32x32 register file (dest / write_enable / data_in) between two writeback requesters: A (ALU) and B (load unit).
- Each requester gets a one-entry holding buffer with a valid/ready handshake.
- A round-robin arbiter drains the buffers into a registered write port, so at most one register-file write happens per cycle.
- The block sits between the execute/memory stages and the register file and also keeps a saturating conflict counter.

Parameters:
- DATA_W, 32, width of write data.
- ADDR_W, 5, width of register index.
- CNT_W, 16, width of conflict_cnt.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- a_valid  in  1  requester A has a write.
- a_ready  out  1  A's buffer can accept.
- a_dest  in  ADDR_W  A destination register.
- a_data  in  DATA_W  A write data.
- b_valid  in  1  requester B has a write.
- b_ready  out  1  B's buffer can accept.
- b_dest  in  ADDR_W  B destination register.
- b_data  in  DATA_W  B write data.
- rf_we  out  1  register-file write_enable, registered.
- rf_dest  out  ADDR_W  register-file dest, registered.
- rf_data  out  DATA_W  register-file data_in, registered.
- last_grant_b  out  1  1 = most recent grant went to B.
- conflict_cnt  out  CNT_W  cycles with both buffers full.

Behaviour:
- Reset (asynchronous, rst_n low), all state cleared:
  - buffers empty; rf_we=0, rf_dest=0, rf_data=0;
  - last_grant_b=1, so A has priority first; conflict_cnt=0.
  - Reset mid-operation discards buffered writes with no partial write.
- Handshake:
  - Transfer on a rising edge when x_valid && x_ready.
  - x_ready = !buf_x_full || grant_x, i.e. the buffer accepts when empty or when it is being drained in the same cycle.
  - x_ready never depends on x_valid.
- x0 filter:
  - An accepted request with dest==0 completes the handshake but is not loaded into the buffer.
  - It never produces rf_we and never consumes a grant.
- Arbitration (combinational, over full buffers):
  - Only A full -> grant A. Only B full -> grant B.
  - Both full -> grant the one not equal to last_grant_b (round-robin).
  - No grant when both are empty.
- Grant edge:
  - The winning buffer's dest/data load into rf_dest/rf_data, rf_we<=1, and the winning buffer clears unless refilled the same edge.
  - last_grant_b updates to the winner.
- No grant: rf_we<=0; rf_dest and rf_data hold their previous values.
- Latency: handshake at edge E0 -> rf_we high in the cycle after E1 -> register file writes at E2. Minimum 2 cycles from accept to write.
- Throughput: 1 write/cycle total. A lone requester sustains 1/cycle. Both streaming alternate A,B,A,B.
- Same dest from both requesters: written in grant order, so the later grant wins the final register value. No merging.
- conflict_cnt increments on every cycle where both buffers are full at the edge, and saturates at all-ones (no wrap).

Optional Feature:
- Macro: REGFILE_WB_BYPASS_EN.
- Defined:
  - Adds inputs rs1_addr and rs2_addr (ADDR_W) and rf_rd1 and rf_rd2 (DATA_W).
  - Adds outputs rs1_data and rs2_data (DATA_W).
  - rsN_data = rf_data when rf_we && rf_dest==rsN_addr && rsN_addr!=0; otherwise rsN_data = rf_rdN.
  - The bypass is purely combinational and gives write-through forwarding for the write currently being presented.
- Undefined: these ports do not exist, and the read path goes straight to the register file outside this block.

Test Plan:
- Reset, then A pulses one request dest=5, data=0xDEADBEEF -> rf_we high exactly 2 cycles after accept with rf_dest=5, rf_data=0xDEADBEEF, then rf_we=0; a_ready stays 1 throughout.
- A and B request simultaneously every cycle for 6 cycles (A dest=1..6, B dest=11..16) -> writes ordered A1,B11,A2,B12,…; no request is lost; conflict_cnt increments while both buffers are full; x_ready shows backpressure.
- A request with dest=0, data=0x1234 -> handshake completes, no rf_we pulse; a following B dest=3 request is granted with no extra delay.
- Assert rst_n low while both buffers are full and rf_we=1 -> all outputs reset immediately with no write after release; the first post-reset conflict is granted to A.
- Hold both buffers full for more than 2^CNT_W cycles (CNT_W overridden to 4) -> conflict_cnt saturates at 15.
- With REGFILE_WB_BYPASS_EN: while rf_we=1, rf_dest=7, rf_data=0xA5A5A5A5, rs1_addr=7, rs2_addr=8, rf_rd1=0, rf_rd2=0x55 -> rs1_data=0xA5A5A5A5 and rs2_data=0x55. Repeat with rf_dest=0 and rs1_addr=0 -> rs1_data=rf_rd1.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: two one-entry buffers (A=ALU, B=load) drained round-robin
// into a registered register-file write port, plus a saturating conflict counter.
// Ports: clk, rst_n; A/B valid/ready/dest/data; rf_we/rf_dest/rf_data;
// last_grant_b; conflict_cnt. With REGFILE_WB_BYPASS_EN defined, also
// rs1_addr/rs2_addr, rf_rd1/rf_rd2 in and rs1_data/rs2_data out (write-through).
module regfile_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_dest,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_dest,
  input  logic [DATA_W-1:0] b_data,
`ifdef REGFILE_WB_BYPASS_EN
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  input  logic [DATA_W-1:0] rf_rd1,
  input  logic [DATA_W-1:0] rf_rd2,
  output logic [DATA_W-1:0] rs1_data,
  output logic [DATA_W-1:0] rs2_data,
`endif
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_dest,
  output logic [DATA_W-1:0] rf_data,
  output logic              last_grant_b,
  output logic [CNT_W-1:0]  conflict_cnt
);

  logic              a_full_q, a_full_d;
  logic [ADDR_W-1:0] a_dest_q, a_dest_d;
  logic [DATA_W-1:0] a_data_q, a_data_d;
  logic              b_full_q, b_full_d;
  logic [ADDR_W-1:0] b_dest_q, b_dest_d;
  logic [DATA_W-1:0] b_data_q, b_data_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] dest_q, dest_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              lgb_q, lgb_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic grant_a, grant_b;
  logic load_a, load_b;

  // Round-robin: on a conflict the side that did not win last time goes.
  assign grant_a = a_full_q && (!b_full_q || lgb_q);
  assign grant_b = b_full_q && (!a_full_q || !lgb_q);

  assign a_ready = !a_full_q || grant_a;
  assign b_ready = !b_full_q || grant_b;

  // Writes to x0 are accepted and dropped here.
  assign load_a = a_valid && a_ready && (a_dest != '0);
  assign load_b = b_valid && b_ready && (b_dest != '0);

  always_comb begin
    a_full_d = a_full_q;
    a_dest_d = a_dest_q;
    a_data_d = a_data_q;
    b_full_d = b_full_q;
    b_dest_d = b_dest_q;
    b_data_d = b_data_q;
    dest_d   = dest_q;
    data_d   = data_q;
    lgb_d    = lgb_q;
    cnt_d    = cnt_q;
    we_d     = grant_a || grant_b;
    if (grant_a) a_full_d = 1'b0;
    if (grant_b) b_full_d = 1'b0;
    if (load_a) begin
      a_full_d = 1'b1;
      a_dest_d = a_dest;
      a_data_d = a_data;
    end
    if (load_b) begin
      b_full_d = 1'b1;
      b_dest_d = b_dest;
      b_data_d = b_data;
    end
    unique case (1'b1)
      grant_a: begin
        dest_d = a_dest_q;
        data_d = a_data_q;
        lgb_d  = 1'b0;
      end
      grant_b: begin
        dest_d = b_dest_q;
        data_d = b_data_q;
        lgb_d  = 1'b1;
      end
      default: ;
    endcase
    if (a_full_q && b_full_q && (cnt_q != '1))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_full_q <= 1'b0;
      a_dest_q <= '0;
      a_data_q <= '0;
      b_full_q <= 1'b0;
      b_dest_q <= '0;
      b_data_q <= '0;
      we_q     <= 1'b0;
      dest_q   <= '0;
      data_q   <= '0;
      lgb_q    <= 1'b1;
      cnt_q    <= '0;
    end else begin
      a_full_q <= a_full_d;
      a_dest_q <= a_dest_d;
      a_data_q <= a_data_d;
      b_full_q <= b_full_d;
      b_dest_q <= b_dest_d;
      b_data_q <= b_data_d;
      we_q     <= we_d;
      dest_q   <= dest_d;
      data_q   <= data_d;
      lgb_q    <= lgb_d;
      cnt_q    <= cnt_d;
    end
  end

  assign rf_we        = we_q;
  assign rf_dest      = dest_q;
  assign rf_data      = data_q;
  assign last_grant_b = lgb_q;
  assign conflict_cnt = cnt_q;

`ifdef REGFILE_WB_BYPASS_EN
  // Forward the write being presented this cycle; x0 is never forwarded.
  assign rs1_data = (we_q && dest_q == rs1_addr && rs1_addr != '0)
                  ? data_q : rf_rd1;
  assign rs2_data = (we_q && dest_q == rs2_addr && rs2_addr != '0)
                  ? data_q : rf_rd2;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter against a transaction-level
// model (pending-write queues, round-robin rule, saturating counter).
module tb_regfile_wb_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          a_valid = 1'b0, b_valid = 1'b0;
  logic          a_ready, b_ready;
  logic [AW-1:0] a_dest = '0, b_dest = '0;
  logic [DW-1:0] a_data = '0, b_data = '0;
  logic          rf_we;
  logic [AW-1:0] rf_dest;
  logic [DW-1:0] rf_data;
  logic          last_grant_b;
  logic [CW-1:0] conflict_cnt;
  logic [AW-1:0] rs1_addr = '0, rs2_addr = '0;
  logic [DW-1:0] rf_rd1 = '0, rf_rd2 = '0;
  logic [DW-1:0] rs1_data, rs2_data;

  regfile_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready),
    .a_dest(a_dest), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready),
    .b_dest(b_dest), .b_data(b_data),
`ifdef REGFILE_WB_BYPASS_EN
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
`endif
    .rf_we(rf_we), .rf_dest(rf_dest), .rf_data(rf_data),
    .last_grant_b(last_grant_b), .conflict_cnt(conflict_cnt)
  );

`ifndef REGFILE_WB_BYPASS_EN
  assign rs1_data = '0;
  assign rs2_data = '0;
`endif

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] d;
    logic [DW-1:0] v;
  } req_t;

  req_t qa[$];
  req_t qb[$];
  logic [AW-1:0] wlog[$];
  bit            m_we;
  logic [AW-1:0] m_dest;
  logic [DW-1:0] m_data;
  bit            m_last;
  int            m_cnt;
  bit            acc_a, acc_b;
  int vectors = 0;
  int miscompares = 0;

  task automatic model_reset();
    qa.delete();
    qb.delete();
    m_we = 0;
    m_dest = '0;
    m_data = '0;
    m_last = 1;
    m_cnt = 0;
  endtask

  task automatic step(input bit av, input logic [AW-1:0] ad,
                      input logic [DW-1:0] adt, input bit bv,
                      input logic [AW-1:0] bd, input logic [DW-1:0] bdt);
    bit ga, gb, era, erb, both;
    a_valid = av; a_dest = ad; a_data = adt;
    b_valid = bv; b_dest = bd; b_data = bdt;
    @(negedge clk);
    ga = qa.size() != 0 && (qb.size() == 0 || m_last);
    gb = qb.size() != 0 && !ga;
    era = qa.size() == 0 || ga;
    erb = qb.size() == 0 || gb;
    vectors += 2;
    if (a_ready !== era) begin
      miscompares++;
      $display("FAIL a_ready got %b want %b t=%0t", a_ready, era, $time);
    end
    if (b_ready !== erb) begin
      miscompares++;
      $display("FAIL b_ready got %b want %b t=%0t", b_ready, erb, $time);
    end
    acc_a = av && era;
    acc_b = bv && erb;
    both = qa.size() != 0 && qb.size() != 0;
    if (ga) begin
      m_we = 1; m_dest = qa[0].d; m_data = qa[0].v;
      void'(qa.pop_front());
      m_last = 0;
    end else if (gb) begin
      m_we = 1; m_dest = qb[0].d; m_data = qb[0].v;
      void'(qb.pop_front());
      m_last = 1;
    end else begin
      m_we = 0;
    end
    if (both && m_cnt < CMAX) m_cnt++;
    if (acc_a && ad != 0) qa.push_back('{ad, adt});
    if (acc_b && bd != 0) qb.push_back('{bd, bdt});
    @(posedge clk);
    #1;
    vectors += 5;
    if (rf_we !== m_we) begin
      miscompares++;
      $display("FAIL rf_we got %b want %b t=%0t", rf_we, m_we, $time);
    end
    if (rf_dest !== m_dest) begin
      miscompares++;
      $display("FAIL rf_dest got %0d want %0d t=%0t", rf_dest, m_dest, $time);
    end
    if (rf_data !== m_data) begin
      miscompares++;
      $display("FAIL rf_data got %h want %h t=%0t", rf_data, m_data, $time);
    end
    if (last_grant_b !== m_last) begin
      miscompares++;
      $display("FAIL last_grant_b got %b want %b t=%0t", last_grant_b, m_last, $time);
    end
    if (conflict_cnt !== CW'(m_cnt)) begin
      miscompares++;
      $display("FAIL conflict_cnt got %0d want %0d t=%0t", conflict_cnt, m_cnt, $time);
    end
    if (rf_we === 1'b1) wlog.push_back(rf_dest);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, '0, '0, 0, '0, '0);
  endtask

  task automatic check_reset_outputs(input string tag);
    vectors++;
    if (rf_we !== 1'b0 || rf_dest !== '0 || rf_data !== '0 ||
        last_grant_b !== 1'b1 || conflict_cnt !== '0 ||
        a_ready !== 1'b1 || b_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s got we=%b dest=%0d data=%h lgb=%b cnt=%0d ar=%b br=%b want 0/0/0/1/0/1/1",
               tag, rf_we, rf_dest, rf_data, last_grant_b, conflict_cnt, a_ready, b_ready);
    end
  endtask

  task automatic test_reset();
    model_reset();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset_state");
    rst_n = 1;
    idle(2);
  endtask

  task automatic test_single();
    wlog.delete();
    step(1, 5'd5, 32'hDEADBEEF, 0, '0, '0);
    vectors++;
    if (rf_we !== 1'b0) begin
      miscompares++;
      $display("FAIL single_early got we=%b want 0", rf_we);
    end
    step(0, '0, '0, 0, '0, '0);
    vectors++;
    if (rf_we !== 1'b1 || rf_dest !== 5'd5 || rf_data !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL single_write got we=%b d=%0d v=%h want 1/5/deadbeef",
               rf_we, rf_dest, rf_data);
    end
    idle(2);
    vectors++;
    if (wlog.size() != 1) begin
      miscompares++;
      $display("FAIL single_count got %0d writes want 1", wlog.size());
    end
  endtask

  task automatic test_x0();
    wlog.delete();
    step(1, 5'd0, 32'h1234, 0, '0, '0);
    step(0, '0, '0, 1, 5'd3, 32'h3333);
    step(0, '0, '0, 0, '0, '0);
    vectors++;
    if (rf_we !== 1'b1 || rf_dest !== 5'd3) begin
      miscompares++;
      $display("FAIL x0_follow got we=%b d=%0d want 1/3", rf_we, rf_dest);
    end
    idle(2);
    vectors++;
    if (wlog.size() != 1) begin
      miscompares++;
      $display("FAIL x0_count got %0d writes want 1", wlog.size());
    end
  endtask

  task automatic test_back_to_back();
    int ia, ib, n;
    logic [AW-1:0] exp_order[$];
    ia = 0; ib = 0; n = 0;
    wlog.delete();
    while ((ia < 6 || ib < 6) && n < 60) begin
      step(ia < 6, AW'(ia + 1), DW'(32'hA000 + ia),
           ib < 6, AW'(ib + 11), DW'(32'hB000 + ib));
      if (acc_a && ia < 6) ia++;
      if (acc_b && ib < 6) ib++;
      n++;
    end
    vectors++;
    if (n >= 60) begin
      miscompares++;
      $display("FAIL b2b_timeout got ia=%0d ib=%0d want 6/6", ia, ib);
    end
    idle(4);
    for (int i = 0; i < 6; i++) begin
      exp_order.push_back(AW'(i + 1));
      exp_order.push_back(AW'(i + 11));
    end
    vectors++;
    if (wlog.size() != exp_order.size()) begin
      miscompares++;
      $display("FAIL b2b_count got %0d want %0d", wlog.size(), exp_order.size());
    end else begin
      for (int i = 0; i < exp_order.size(); i++) begin
        vectors++;
        if (wlog[i] !== exp_order[i]) begin
          miscompares++;
          $display("FAIL b2b_order[%0d] got %0d want %0d", i, wlog[i], exp_order[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    step(1, 5'd9, 32'h9, 1, 5'd10, 32'h10);
    step(1, 5'd19, 32'h19, 1, 5'd20, 32'h20);
    vectors++;
    if (rf_we !== 1'b1 || qa.size() != 1 || qb.size() != 1) begin
      miscompares++;
      $display("FAIL mid_setup got we=%b want 1 with both buffers full", rf_we);
    end
    a_valid = 0; b_valid = 0;
    #2;
    rst_n = 0;
    #1;
    model_reset();
    check_reset_outputs("reset_async");
    @(posedge clk);
    #1;
    rst_n = 1;
    wlog.delete();
    idle(3);
    step(1, 5'd21, 32'h21, 1, 5'd22, 32'h22);
    idle(3);
    vectors++;
    if (wlog.size() != 2 || wlog[0] !== 5'd21) begin
      miscompares++;
      $display("FAIL post_reset_first got n=%0d first=%0d want 2/21",
               wlog.size(), wlog.size() ? wlog[0] : '0);
    end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 2 * (CMAX + 1) + 4; i++)
      step(1, AW'(1 + (i % 30)), $urandom, 1, AW'(2 + (i % 29)), $urandom);
    vectors++;
    if (conflict_cnt !== CW'(CMAX)) begin
      miscompares++;
      $display("FAIL saturate got %0d want %0d", conflict_cnt, CMAX);
    end
    idle(3);
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 1), AW'($urandom_range(0, 31)), $urandom,
           $urandom_range(0, 1), AW'($urandom_range(0, 31)), $urandom);
    idle(3);
  endtask

  task automatic test_bypass();
`ifdef REGFILE_WB_BYPASS_EN
    logic [DW-1:0] e1, e2;
    step(1, 5'd7, 32'hA5A5A5A5, 0, '0, '0);
    step(0, '0, '0, 0, '0, '0);
    rs1_addr = 5'd7; rs2_addr = 5'd8;
    rf_rd1 = '0; rf_rd2 = 32'h55;
    #1;
    e1 = (m_we && m_dest == rs1_addr && rs1_addr != 0) ? m_data : rf_rd1;
    e2 = (m_we && m_dest == rs2_addr && rs2_addr != 0) ? m_data : rf_rd2;
    vectors += 2;
    if (rs1_data !== e1 || e1 !== 32'hA5A5A5A5) begin
      miscompares++;
      $display("FAIL bypass_rs1 got %h want %h", rs1_data, e1);
    end
    if (rs2_data !== e2) begin
      miscompares++;
      $display("FAIL bypass_rs2 got %h want %h", rs2_data, e2);
    end
    rs1_addr = 5'd0; rf_rd1 = 32'h77;
    #1;
    vectors++;
    if (rs1_data !== 32'h77) begin
      miscompares++;
      $display("FAIL bypass_x0 got %h want 00000077", rs1_data);
    end
    idle(1);
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_x0();
    test_back_to_back();
    test_reset_mid();
    test_saturate();
    test_random();
    test_bypass();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
